yapp_router_n: RTL and testbench

Parametrised YAPP packet router: it accepts YAPP packets on one byte-serial input and routes each packet to one of NUM_CH output channels, with a FIFO per channel. An HBUS register port provides enables, a maximum-length filter and error counters. It replaces the fixed three-channel router and drops directly into the same testbench top beside the YAPP, HBUS, channel and clock/reset interfaces.

---
 rtl/yapp_router_n.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_yapp_router_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/yapp_router_n.sv
// YAPP packet router: one byte-serial input, NUM_CH output channels each behind a FIFO, HBUS registers.
// Define YAPP_ROUTER_STATS_EN to build the parity-error and drop counters (HBUS 0x03/0x04).
module yapp_router_n_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      stall_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      rvld_o,
  output logic [$clog2(DEPTH):0]    cnt_nxt_o,
  output logic                      ovf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE  = 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW:0]       wp_q, rp_q, cnt;
  logic              full, pop, wr;

  assign cnt       = wp_q - rp_q;
  assign full      = (cnt == FULL);
  assign pop       = (cnt != '0) && !stall_i;
  // A pop frees the head slot on the same edge, so a full FIFO may still accept.
  assign wr        = push_i && (!full || pop);
  assign ovf_o     = push_i && !wr;
  assign cnt_nxt_o = cnt + (PW+1)'(wr) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[PW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      rdata_o <= '0;
      rvld_o  <= 1'b0;
    end else begin
      if (wr) wp_q <= wp_q + ONE;
      if (pop) begin
        rp_q    <= rp_q + ONE;
        rdata_o <= mem_q[rp_q[PW-1:0]];
      end
      rvld_o <= pop;
    end
  end
endmodule

module yapp_router_n #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_data_vld,
  output logic                       in_suspend,
  output logic [NUM_CH*DATA_W-1:0]   data,
  output logic [NUM_CH-1:0]          data_vld,
  input  logic [NUM_CH-1:0]          suspend,
  input  logic [7:0]                 haddr,
  input  logic [7:0]                 hdata_in,
  output logic [7:0]                 hdata_out,
  input  logic                       hen,
  input  logic                       hwr_rd,
  output logic                       error
);
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HIGH_LVL = CNT_W'(FIFO_DEPTH-1);
  localparam logic [LEN_W:0]   CNT_ONE  = 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAR, S_DROP} state_t;

  state_t              state_q, state_d, eff;
  logic [LEN_W:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   par_q, par_d;
  logic                push_q, push_d, push_first_q, push_first_d;
  logic [ADDR_W-1:0]   push_ch_q, push_ch_d;
  logic [DATA_W-1:0]   push_data_q, push_data_d;
  logic                ovf_seen_q, ovf_seen_d, seen_eff;
  logic                in_suspend_q, in_suspend_d, error_q;
  logic                par_err, hdr_drop, drop_ovf, hdr_ok;

  logic [LEN_W-1:0]    max_len_q;
  logic                router_en_q;
  logic [NUM_CH-1:0]   ch_en_q;
  logic [(1<<ADDR_W)-1:0] ch_en_ext;
  logic [7:0]          hdata_out_q, rd_data, par_err_cnt_q, drop_cnt_q;
  logic                wr_en, rd_en;

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic [NUM_CH-1:0]   fifo_ovf;
  logic [DATA_W-1:0]   fifo_data [NUM_CH];
  logic [CNT_W-1:0]    cnt_nxt [NUM_CH];
  logic [CNT_W-1:0]    occ [NUM_CH];

  assign hdr_addr = in_data[ADDR_W-1:0];
  assign hdr_len  = in_data[DATA_W-1:ADDR_W];
  assign wr_en    = hen && hwr_rd;
  assign rd_en    = hen && !hwr_rd;

  always_comb begin
    ch_en_ext = '0;
    ch_en_ext[NUM_CH-1:0] = ch_en_q;
  end

  assign hdr_ok = router_en_q && (32'(hdr_addr) < NUM_CH) && ch_en_ext[hdr_addr] &&
                  (hdr_len <= max_len_q);

  // Input FSM. Accepted bytes are staged in push_* and land in the FIFO one edge later,
  // which is the cycle the header spends in S_HDR.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dest_d       = dest_q;
    par_d        = par_q;
    push_d       = 1'b0;
    push_first_d = 1'b0;
    push_ch_d    = dest_q;
    push_data_d  = in_data;
    par_err      = 1'b0;
    hdr_drop     = 1'b0;
    eff          = state_q;
    if (state_q == S_HDR) eff = (cnt_q == '0) ? S_PAR : S_PAY;
    state_d = eff;
    case (eff)
      S_IDLE: if (in_data_vld) begin
        if (hdr_ok) begin
          state_d      = S_HDR;
          dest_d       = hdr_addr;
          cnt_d        = {1'b0, hdr_len};
          par_d        = in_data;
          push_d       = 1'b1;
          push_first_d = 1'b1;
          push_ch_d    = hdr_addr;
        end else begin
          state_d  = S_DROP;
          cnt_d    = {1'b0, hdr_len} + CNT_ONE;
          hdr_drop = 1'b1;
        end
      end
      S_PAY: if (in_data_vld) begin
        push_d = 1'b1;
        par_d  = par_q ^ in_data;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_PAR;
      end
      S_PAR: if (in_data_vld) begin
        push_d  = 1'b1;
        par_err = (in_data != par_q);
        state_d = S_IDLE;
      end
      S_DROP: if (in_data_vld) begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  // Overflow is reported once per packet; the header push re-arms the detector.
  assign seen_eff   = (push_q && push_first_q) ? 1'b0 : ovf_seen_q;
  assign drop_ovf   = (|fifo_ovf) && !seen_eff;
  assign ovf_seen_d = seen_eff || (|fifo_ovf);

  // Occupancy counts the byte staged this edge so the registered in_suspend stays safe.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      occ[k] = cnt_nxt[k] + {{(CNT_W-1){1'b0}}, push_d && (32'(push_ch_d) == k)};
    in_suspend_d = 1'b0;
    case (state_d)
      S_HDR, S_PAY, S_PAR: in_suspend_d = (occ[dest_d] >= HIGH_LVL);
      S_IDLE: for (int k = 0; k < NUM_CH; k++)
        if (ch_en_q[k] && (occ[k] >= FULL_LVL)) in_suspend_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dest_q       <= '0;
      par_q        <= '0;
      push_q       <= 1'b0;
      push_first_q <= 1'b0;
      push_ch_q    <= '0;
      push_data_q  <= '0;
      ovf_seen_q   <= 1'b0;
      in_suspend_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dest_q       <= dest_d;
      par_q        <= par_d;
      push_q       <= push_d;
      push_first_q <= push_first_d;
      push_ch_q    <= push_ch_d;
      push_data_q  <= push_data_d;
      ovf_seen_q   <= ovf_seen_d;
      in_suspend_q <= in_suspend_d;
      error_q      <= par_err || drop_ovf;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    yapp_router_n_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clock),
      .rst_n     (reset),
      .push_i    (push_q && (32'(push_ch_q) == k)),
      .wdata_i   (push_data_q),
      .stall_i   (suspend[k]),
      .rdata_o   (fifo_data[k]),
      .rvld_o    (data_vld[k]),
      .cnt_nxt_o (cnt_nxt[k]),
      .ovf_o     (fifo_ovf[k])
    );
    assign data[k*DATA_W +: DATA_W] = fifo_data[k];
  end

  always_comb begin
    rd_data = '0;
    case (haddr)
      8'h00: rd_data = 8'(max_len_q);
      8'h01: rd_data = {7'b0, router_en_q};
      8'h02: rd_data = 8'(ch_en_q);
      8'h03: rd_data = par_err_cnt_q;
      8'h04: rd_data = drop_cnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      max_len_q   <= '1;
      router_en_q <= 1'b1;
      ch_en_q     <= '1;
      hdata_out_q <= '0;
    end else begin
      if (wr_en) begin
        case (haddr)
          8'h00: max_len_q   <= LEN_W'(hdata_in);
          8'h01: router_en_q <= hdata_in[0];
          8'h02: ch_en_q     <= NUM_CH'(hdata_in);
          default: ;
        endcase
      end
      if (rd_en) hdata_out_q <= rd_data;
    end
  end

`ifdef YAPP_ROUTER_STATS_EN
  logic [8:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt_q} + 9'(hdr_drop) + 9'(drop_ovf);

  always_ff @(posedge clock) begin
    if (!reset) begin
      par_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (wr_en && haddr == 8'h03)             par_err_cnt_q <= '0;
      else if (par_err && par_err_cnt_q != '1) par_err_cnt_q <= par_err_cnt_q + 8'd1;
      if (wr_en && haddr == 8'h04)             drop_cnt_q <= '0;
      else                                     drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`else
  logic unused_hdr_drop;
  assign unused_hdr_drop = hdr_drop;
  assign par_err_cnt_q   = '0;
  assign drop_cnt_q      = '0;
`endif

  assign in_suspend = in_suspend_q;
  assign error      = error_q;
  assign hdata_out  = hdata_out_q;
endmodule

// File: tb/tb_yapp_router_n.sv
// Scoreboard bench for yapp_router_n (3 channels, 8-bit bytes, 16-deep FIFOs).
module tb_yapp_router_n;
`ifdef YAPP_ROUTER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_data_vld;
  logic        in_suspend;
  logic [23:0] data;
  logic [2:0]  data_vld;
  logic [2:0]  suspend;
  logic [7:0]  haddr, hdata_in, hdata_out;
  logic        hen, hwr_rd, error;

  yapp_router_n #(.NUM_CH(3), .ADDR_W(2), .DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_data_vld(in_data_vld),
    .in_suspend(in_suspend), .data(data), .data_vld(data_vld), .suspend(suspend),
    .haddr(haddr), .hdata_in(hdata_in), .hdata_out(hdata_out), .hen(hen),
    .hwr_rd(hwr_rd), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, err_pulses = 0;
  int out_cnt [3];
  logic [7:0] exp_q [3][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented byte is compared against the channel's expected queue.
  always @(negedge clock) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        if (data_vld[k]) begin
          out_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL out_ch%0d unexpected byte got=%02h want=none", k, data[k*8 +: 8]);
          end else begin
            logic [7:0] e;
            e = exp_q[k].pop_front();
            check($sformatf("out_ch%0d", k), 32'(data[k*8 +: 8]), 32'(e));
          end
        end
      end
      if (error) err_pulses++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (in_suspend && n < 2000) begin @(negedge clock); n++; end
    if (n >= 2000) check("send_timeout", 32'(n), 32'(0));
    in_data = b; in_data_vld = 1'b1;
    @(negedge clock);
    in_data_vld = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base,
                          input logic [7:0] flip, input int exp_ch);
    logic [7:0] p, b;
    int len;
    len = int'(hdr >> 2);
    p = hdr;
    if (exp_ch >= 0) exp_q[exp_ch].push_back(hdr);
    send_byte(hdr);
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      p = p ^ b;
      if (exp_ch >= 0) exp_q[exp_ch].push_back(b);
      send_byte(b);
    end
    if (exp_ch >= 0) exp_q[exp_ch].push_back(p ^ flip);
    send_byte(p ^ flip);
  endtask

  task automatic hbus_write(input logic [7:0] a, input logic [7:0] d);
    haddr = a; hdata_in = d; hwr_rd = 1'b1; hen = 1'b1;
    @(negedge clock);
    hen = 1'b0;
  endtask

  task automatic hbus_read(input logic [7:0] a, output logic [7:0] d);
    haddr = a; hwr_rd = 1'b0; hen = 1'b1;
    @(negedge clock);
    hen = 1'b0;
    d = hdata_out;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 1000) begin
      @(negedge clock); n++;
    end
    check("drain_left", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'(0));
    repeat (6) @(negedge clock);
  endtask

  logic [7:0] rd;
  int base_err, base0, base_out, saw_susp, out_at_susp, wait_n;

  initial begin
    reset = 1'b0; in_data = '0; in_data_vld = 1'b0; suspend = '0;
    haddr = '0; hdata_in = '0; hen = 1'b0; hwr_rd = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_suspend", 32'(in_suspend), 0);
    check("rst_data_vld",   32'(data_vld), 0);
    check("rst_data",       32'(data), 0);
    check("rst_error",      32'(error), 0);
    check("rst_hdata_out",  32'(hdata_out), 0);
    reset = 1'b1;
    @(negedge clock);
    hbus_read(8'h00, rd); check("rst_max_len", 32'(rd), 32'h3F);
    hbus_read(8'h01, rd); check("rst_router_en", 32'(rd), 32'h01);
    hbus_read(8'h02, rd); check("rst_ch_en", 32'(rd), 32'h07);

    // Good packet to channel 1, then zero-length packets to channels 0 and 2.
    base_err = err_pulses;
    send_pkt(8'h0D, 8'hA1, 8'h00, 1);
    send_pkt(8'h00, 8'h00, 8'h00, 0);
    send_pkt(8'h02, 8'h00, 8'h00, 2);
    wait_drain();
    check("good_pkt_no_error", 32'(err_pulses - base_err), 0);

    // Bad parity: byte still delivered, one error pulse, counter = 1.
    base_err = err_pulses;
    send_pkt(8'h0D, 8'hA1, 8'h01, 1);
    wait_drain();
    check("bad_par_pulses", 32'(err_pulses - base_err), 1);
    hbus_read(8'h03, rd); check("par_err_cnt", 32'(rd), 32'(STATS));

    // Out-of-range address, then disabled channel: both dropped.
    base_err = err_pulses; base_out = out_cnt[0] + out_cnt[1] + out_cnt[2];
    send_pkt(8'h0B, 8'h30, 8'h00, -1);
    hbus_write(8'h02, 8'h05);
    send_pkt(8'h0D, 8'h40, 8'h00, -1);
    repeat (10) @(negedge clock);
    check("drop_no_output", 32'(out_cnt[0] + out_cnt[1] + out_cnt[2] - base_out), 0);
    check("drop_no_error", 32'(err_pulses - base_err), 0);
    hbus_read(8'h04, rd); check("drop_cnt", 32'(rd), 32'(2 * STATS));
    hbus_write(8'h04, 8'h00);
    hbus_read(8'h04, rd); check("drop_cnt_clr", 32'(rd), 0);
    hbus_write(8'h02, 8'h07);
    hbus_read(8'h02, rd); check("ch_en_wr", 32'(rd), 32'h07);

    // Stalled sink: 22-byte packet to channel 0 must back-pressure without overflow.
    base_err = err_pulses; base0 = out_cnt[0]; saw_susp = 0; wait_n = 0;
    suspend[0] = 1'b1;
    fork
      send_pkt(8'h50, 8'h10, 8'h00, 0);
      begin
        while (!in_suspend && wait_n < 200) begin @(negedge clock); wait_n++; end
        saw_susp = int'(in_suspend);
        out_at_susp = out_cnt[0] - base0;
        repeat (8) @(negedge clock);
        suspend[0] = 1'b0;
      end
    join
    wait_drain();
    check("susp_raised", 32'(saw_susp), 1);
    check("susp_while_stalled", 32'(out_at_susp), 0);
    check("susp_all_bytes", 32'(out_cnt[0] - base0), 22);
    check("susp_no_error", 32'(err_pulses - base_err), 0);

    // Length filter: len 5 > max_len 4 is dropped (7 bytes), len 4 routes.
    hbus_write(8'h00, 8'h04);
    base_out = out_cnt[2];
    send_pkt(8'h16, 8'h50, 8'h00, -1);
    repeat (6) @(negedge clock);
    check("maxlen_drop", 32'(out_cnt[2] - base_out), 0);
    send_pkt(8'h12, 8'h60, 8'h00, 2);
    wait_drain();
    check("maxlen_route", 32'(out_cnt[2] - base_out), 6);
    hbus_read(8'h04, rd); check("maxlen_drop_cnt", 32'(rd), 32'(STATS));
    hbus_read(8'h00, rd); check("max_len_wr", 32'(rd), 32'h04);

    // Reset mid-payload with channel 1 stalled so the partial packet is still buffered.
    base_err = err_pulses;
    suspend[1] = 1'b1;
    send_byte(8'h0D); send_byte(8'hA1); send_byte(8'hA2);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_data_vld",   32'(data_vld), 0);
    check("mid_rst_data",       32'(data), 0);
    check("mid_rst_in_suspend", 32'(in_suspend), 0);
    check("mid_rst_error",      32'(error), 0);
    check("mid_rst_hdata_out",  32'(hdata_out), 0);
    reset = 1'b1; suspend[1] = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_rst_no_error", 32'(err_pulses - base_err), 0);
    hbus_read(8'h00, rd); check("mid_rst_max_len", 32'(rd), 32'h3F);
    send_pkt(8'h0D, 8'hB0, 8'h00, 1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
